rtc_counter: RTL and testbench

- Time-of-day timekeeper. Divides the system clock to a 1 Hz tick and keeps second/minute/hour in 24-hour binary.
- Supports user time-setting through a small mode FSM.
- Sits directly upstream of the alarm comparator: its minute and hour outputs feed that block's time inputs.
- Also provides second and day-rollover pulses for the display and calendar stages.

---
 rtl/rtc_pkg.sv | 19 +
 rtl/rtc_counter_wrap_counter.sv | 35 +++
 rtl/rtc_counter.sv | 119 +++++++++++
 tb/tb_rtc_counter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared encodings and limits for the real-time-clock timekeeper.
// Field widths hold 0..59 for second and minute, and 0..23 for hour.
package rtc_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HOUR_W   = 5;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

endpackage

// File: rtl/rtc_counter_wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear.
// carry is high while en is high and the count sits at MAX, so carries can be chained.
module wrap_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         carry
);

  logic [W-1:0] value_q, value_d;
  logic         at_max;

  assign at_max = (value_q == W'(MAX));
  assign carry  = en && at_max;
  assign value  = value_q;

  // clr takes priority over en
  always_comb begin
    value_d = value_q;
    if (clr)         value_d = '0;
    else if (carry)  value_d = '0;
    else if (en)     value_d = value_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

endmodule

// File: rtl/rtc_counter.sv
// Time-of-day timekeeper: 1 Hz prescaler, sec/min/hour chain, and a
// NORMAL -> SET_HOUR -> SET_MIN mode FSM for setting the time.
module rtc_counter
  import rtc_pkg::*;
#(
  parameter int CLK_DIV = 50000000,
  parameter int DIV_W   = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_i,
  input  logic              inc_i,
  output logic [SEC_W-1:0]  second,
  output logic [MIN_W-1:0]  minute,
  output logic [HOUR_W-1:0] hour,
  output logic              sec_tick_o,
  output logic              day_tick_o,
  output logic [1:0]        set_mode_o
);

  mode_e            mode_q, mode_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             sec_tick_q, sec_tick_d;
  logic             day_tick_q, day_tick_d;

  logic sec_en, sec_clr, min_en, hour_en;
  logic sec_carry, min_carry, hour_carry;
  logic term_cnt;

  assign term_cnt = (presc_q == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_NORMAL;
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      presc_q    <= presc_d;
      sec_tick_q <= sec_tick_d;
      day_tick_q <= day_tick_d;
    end
  end

  // A mode pulse always wins over an inc pulse or a terminal count
  // arriving on the same edge.
  always_comb begin
    mode_d     = mode_q;
    presc_d    = '0;
    sec_en     = 1'b0;
    sec_clr    = 1'b0;
    min_en     = 1'b0;
    hour_en    = 1'b0;
    sec_tick_d = 1'b0;
    day_tick_d = 1'b0;
    unique case (mode_q)
      MODE_NORMAL: begin
        if (mode_i) begin
          mode_d  = MODE_SET_HOUR;
          sec_clr = 1'b1;
        end else if (term_cnt) begin
          sec_en     = 1'b1;
          min_en     = sec_carry;
          hour_en    = sec_carry && min_carry;
          sec_tick_d = 1'b1;
          day_tick_d = hour_carry;
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      MODE_SET_HOUR: begin
        sec_clr = 1'b1;
        if (mode_i)     mode_d  = MODE_SET_MIN;
        else if (inc_i) hour_en = 1'b1;
      end
      MODE_SET_MIN: begin
        sec_clr = 1'b1;
        if (mode_i)     mode_d = MODE_NORMAL;
        else if (inc_i) min_en = 1'b1;
      end
      default: mode_d = MODE_NORMAL;
    endcase
  end

  wrap_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sec_en),
    .clr   (sec_clr),
    .value (second),
    .carry (sec_carry)
  );

  // Minute wraps without touching hour in SET_MIN because hour_en is
  // only driven from the NORMAL carry path there.
  wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (min_en),
    .clr   (1'b0),
    .value (minute),
    .carry (min_carry)
  );

  wrap_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hour_en),
    .clr   (1'b0),
    .value (hour),
    .carry (hour_carry)
  );

  assign sec_tick_o = sec_tick_q;
  assign day_tick_o = day_tick_q;
  assign set_mode_o = mode_q;

endmodule

// File: tb/tb_rtc_counter.sv
// Bench for rtc_counter: directed set/rollover/collision/reset steps plus
// random pulses, checked every cycle against a seconds-of-day model.
module tb_rtc_counter;

  localparam int CLK_DIV = 4;
  localparam int DIV_W   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_i = 1'b0;
  logic       inc_i = 1'b0;
  logic [5:0] second;
  logic [5:0] minute;
  logic [4:0] hour;
  logic       sec_tick_o, day_tick_o;
  logic [1:0] set_mode_o;

  int total = 0;
  int bad   = 0;

  // model: time as seconds since midnight, mode 0/1/2, cycles since last tick
  int m_tod = 0, m_mode = 0, m_phase = 0, m_stk = 0, m_dtk = 0;
  int n_day = 0;

  rtc_counter #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_i     (mode_i),
    .inc_i      (inc_i),
    .second     (second),
    .minute     (minute),
    .hour       (hour),
    .sec_tick_o (sec_tick_o),
    .day_tick_o (day_tick_o),
    .set_mode_o (set_mode_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".sec"},  second,     m_tod % 60);
    chk({tag, ".min"},  minute,     (m_tod / 60) % 60);
    chk({tag, ".hour"}, hour,       m_tod / 3600);
    chk({tag, ".stk"},  sec_tick_o, m_stk);
    chk({tag, ".dtk"},  day_tick_o, m_dtk);
    chk({tag, ".mode"}, set_mode_o, m_mode);
  endtask

  task automatic model_reset();
    m_tod = 0; m_mode = 0; m_phase = 0; m_stk = 0; m_dtk = 0;
  endtask

  task automatic model_step(input int md, input int inc);
    int h, m, s;
    h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
    m_stk = 0; m_dtk = 0;
    case (m_mode)
      0: if (md != 0) begin
           m_mode = 1; m_tod = m_tod - s; m_phase = 0;
         end else begin
           m_phase++;
           if (m_phase == CLK_DIV) begin
             m_phase = 0;
             m_tod = (m_tod + 1) % 86400;
             m_stk = 1;
             m_dtk = (m_tod == 0) ? 1 : 0;
           end
         end
      1: if (md != 0) m_mode = 2;
         else if (inc != 0) m_tod = ((h + 1) % 24) * 3600 + m * 60;
      default: if (md != 0) begin m_mode = 0; m_phase = 0; end
         else if (inc != 0) m_tod = h * 3600 + ((m + 1) % 60) * 60;
    endcase
  endtask

  // one clock: drive, clock, update model, check 1 time unit after the edge
  task automatic cyc(input int md, input int inc, input string tag);
    mode_i = md[0]; inc_i = inc[0];
    @(posedge clk);
    model_step(md, inc);
    #1;
    if (day_tick_o === 1'b1) n_day++;
    chk_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(0, 0, tag);
  endtask

  task automatic pulse_rst(input string tag);
    rst_n = 1'b0;
    mode_i = 1'b0; inc_i = 1'b0;
    #1;
    model_reset();
    chk_all({tag, ".async"});
    @(posedge clk);
    #1;
    chk_all({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt, r;
    // reset state
    #2;
    model_reset();
    chk_all("rst");
    @(posedge clk); #1;
    chk_all("rst_hold");
    rst_n = 1'b1;

    // free run: ticks on cycles 4, 8, 12
    idle(12, "run");
    chk("run.sec3", second, 3);

    // hour setting: 25 incs wrap to 1
    cyc(1, 0, "sh_enter");
    for (int i = 0; i < 25; i++) cyc(0, 1, "sh_inc");
    chk("sh.hour1", hour, 1);
    idle(20, "sh_wait");

    // minute setting: 61 incs wrap to 1, hour untouched
    cyc(1, 0, "sm_enter");
    for (int i = 0; i < 61; i++) cyc(0, 1, "sm_inc");
    chk("sm.min1", minute, 1);
    chk("sm.hour1", hour, 1);
    cyc(1, 0, "sm_exit");
    idle(3, "first_tick_pre");
    cyc(0, 0, "first_tick");
    chk("first_tick.stk", sec_tick_o, 1);

    // set 23:59 then run to 23:59:59 and roll over
    cyc(1, 0, "r_sh");
    for (int i = 0; i < 22; i++) cyc(0, 1, "r_hinc");
    cyc(1, 0, "r_sm");
    for (int i = 0; i < 58; i++) cyc(0, 1, "r_minc");
    cyc(1, 0, "r_norm");
    idle(59 * CLK_DIV, "r_run");
    chk("r.sec59", second, 59);
    n_day = 0;
    idle(CLK_DIV, "roll");
    chk("roll.tod", {hour, minute, second}, 0);
    chk("roll.ndays", n_day, 1);

    // collisions: mode+inc in NORMAL, then mode on terminal count
    cyc(1, 1, "col_modeinc");
    chk("col.hour0", hour, 0);
    cyc(1, 0, "col_sm");
    cyc(1, 0, "col_norm");
    idle(CLK_DIV - 1, "col_pre");
    cyc(1, 0, "col_tc");
    chk("col_tc.stk", sec_tick_o, 0);
    chk("col_tc.sec", second, 0);

    // reset mid SET_MIN at minute 37
    cyc(1, 0, "mr_sm");
    cnt = (37 - (m_tod / 60) % 60 + 60) % 60;
    for (int i = 0; i < cnt; i++) cyc(0, 1, "mr_inc");
    chk("mr.min37", minute, 37);
    pulse_rst("mr");
    idle(CLK_DIV, "mr_resume");
    chk("mr.stk", sec_tick_o, 1);

    // random pulses
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      cyc((r < 4) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0, "rnd");
      if (r == 99) pulse_rst("rnd_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
